// File: rtl/stream_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_arb_pkg
//  Brief    : Shared helpers for the round-robin stream arbiter.
//  Revision : 1.0
// ============================================================================
package stream_arb_pkg;

    // Grant index width; a single input still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : stream_arb_pkg
`default_nettype wire

// File: rtl/stream_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : stream_rr_arbiter_if
//  Brief    : Ready/valid bundle: NumIn input streams plus one merged output.
//  Revision : 1.0
// ============================================================================
interface stream_rr_arbiter_if #(
    parameter type T     = logic,
    parameter int  NumIn = 2,
    parameter int  IdxW  = stream_arb_pkg::idx_width(NumIn)
);
    logic [NumIn-1:0] valid_i;
    logic [NumIn-1:0] ready_o;
    T                 data_i [NumIn];
    logic             valid_o;
    logic             ready_i;
    T                 data_o;
    logic [IdxW-1:0]  idx_o;

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, idx_o
    );

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, idx_o
    );
endinterface : stream_rr_arbiter_if
`default_nettype wire

// File: rtl/stream_rr_arbiter_find_first.sv
`default_nettype none
// ============================================================================
//  Module   : rr_find_first
//  Brief    : First set request at or after start_i, wrapping NumIn-1 -> 0.
//  Revision : 1.0
// ============================================================================
module rr_find_first
    import stream_arb_pkg::*;
#(
    parameter int NumIn = 2,
    parameter int IdxW  = idx_width(NumIn)
) (
    input  logic [NumIn-1:0] req_i,
    input  logic [IdxW-1:0]  start_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             found_o
);
    int w_pos;

    // Walk from the farthest offset down so the nearest request wins last.
    always_comb begin
        idx_o   = start_i;
        found_o = 1'b0;
        w_pos   = 0;
        for (int k = NumIn - 1; k >= 0; k--) begin
            w_pos = int'(start_i) + k;
            if (w_pos >= NumIn) begin
                w_pos = w_pos - NumIn;
            end
            if (req_i[w_pos]) begin
                idx_o   = IdxW'(w_pos);
                found_o = 1'b1;
            end
        end
    end
endmodule : rr_find_first
`default_nettype wire

// File: rtl/stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : stream_rr_arbiter
//  Brief    : Round-robin merge of NumIn ready/valid streams, zero latency.
//             Define STREAM_RR_ARBITER_LOCK_EN to hold a stalled grant.
//  Revision : 1.0
// ============================================================================
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter type T     = logic,
    parameter int  NumIn = 2,
    parameter int  IdxW  = idx_width(NumIn)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    stream_rr_arbiter_if.slave bus
);
    localparam logic [IdxW-1:0] c_last = IdxW'(NumIn - 1);

    logic [IdxW-1:0] rr_q;
    logic [IdxW-1:0] w_ff_idx;
    logic [IdxW-1:0] w_gnt;
    logic [IdxW-1:0] w_rr_next;
    logic            w_found;
    logic            w_valid;
    logic            w_hs;
    T                w_data;

    rr_find_first #(
        .NumIn (NumIn),
        .IdxW  (IdxW)
    ) u_find (
        .req_i   (bus.valid_i),
        .start_i (rr_q),
        .idx_o   (w_ff_idx),
        .found_o (w_found)
    );

`ifdef STREAM_RR_ARBITER_LOCK_EN
    logic            lock_q;
    logic [IdxW-1:0] lock_idx_q;

    always_comb begin
        w_gnt   = lock_q ? lock_idx_q : w_ff_idx;
        w_valid = lock_q ? bus.valid_i[lock_idx_q] : w_found;
    end

    // A stalled beat pins the grant so the output cannot switch under it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (clr_i) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (w_hs) begin
            lock_q     <= 1'b0;
        end else if (w_valid) begin
            lock_q     <= 1'b1;
            lock_idx_q <= w_gnt;
        end
    end
`else
    assign w_gnt   = w_ff_idx;
    assign w_valid = w_found;
`endif

    assign w_hs      = w_valid & bus.ready_i;
    assign w_rr_next = (w_gnt == c_last) ? '0 : w_gnt + IdxW'(1);
    assign w_data    = bus.data_i[w_gnt];

    assign bus.valid_o = w_valid;
    assign bus.data_o  = w_data;
    assign bus.idx_o   = w_gnt;

    always_comb begin
        bus.ready_o        = '0;
        bus.ready_o[w_gnt] = bus.ready_i & w_valid;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (clr_i) begin
            rr_q <= '0;
        end else if (w_hs) begin
            rr_q <= w_rr_next;
        end
    end
endmodule : stream_rr_arbiter
`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_rr_arbiter
//  Brief    : Directed vector bench for stream_rr_arbiter, NumIn=4, 8-bit data.
//  Revision : 1.0
// ============================================================================
module tb_stream_rr_arbiter;
    typedef struct {
        logic       clr;
        logic [3:0] valid;
        logic       ready;
        logic       ev;
        logic [3:0] er;
        logic [1:0] ei;
        string      nm;
    } vec_t;

    logic clk;
    logic rst_ni;
    logic clr_i;
    int   n_vec;
    int   n_err;
    logic [7:0] payload [4];
    vec_t tbl [19];

    stream_rr_arbiter_if #(.T(logic [7:0]), .NumIn(4)) bus ();

    stream_rr_arbiter #(
        .T     (logic [7:0]),
        .NumIn (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string nm, input logic ev, input logic [3:0] er,
                              input logic [1:0] ei);
        check({nm, ".valid_o"}, 32'(bus.valid_o), 32'(ev));
        check({nm, ".ready_o"}, 32'(bus.ready_o), 32'(er));
        check({nm, ".idx_o"},   32'(bus.idx_o),   32'(ei));
        check({nm, ".data_o"},  32'(bus.data_o),  32'(payload[ei]));
    endtask

    // Drive just after the rising edge, sample mid-cycle before the next one.
    task automatic apply(input logic clr, input logic [3:0] valid, input logic ready,
                         input logic ev, input logic [3:0] er, input logic [1:0] ei,
                         input string nm);
        @(posedge clk);
        #1;
        clr_i       = clr;
        bus.valid_i = valid;
        bus.ready_i = ready;
        #4;
        check_outs(nm, ev, er, ei);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        payload[0] = 8'h10;
        payload[1] = 8'h20;
        payload[2] = 8'h30;
        payload[3] = 8'h40;
        for (int i = 0; i < 4; i++) bus.data_i[i] = payload[i];
        rst_ni      = 1'b0;
        clr_i       = 1'b0;
        bus.valid_i = 4'b0000;
        bus.ready_i = 1'b0;

        tbl[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, "idle_after_reset"};
        tbl[1]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, "all_valid_0"};
        tbl[2]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, "all_valid_1"};
        tbl[3]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, "all_valid_2"};
        tbl[4]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, "all_valid_3"};
        tbl[5]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, "all_valid_4"};
        tbl[6]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, "all_valid_5"};
        tbl[7]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, "all_valid_6"};
        tbl[8]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, "all_valid_7"};
        tbl[9]  = '{1'b0, 4'b1010, 1'b1, 1'b1, 4'b0010, 2'd1, "sparse_1"};
        tbl[10] = '{1'b0, 4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3, "sparse_3"};
        tbl[11] = '{1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, "sparse_wrap_1"};
        tbl[12] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd2, "idle_shows_rr2"};
        tbl[13] = '{1'b0, 4'b0001, 1'b0, 1'b1, 4'b0000, 2'd0, "wrap_stall_0"};
        tbl[14] = '{1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, "wrap_accept_0"};
        tbl[15] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1, "idle_shows_rr1"};
        tbl[16] = '{1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, "grant_2"};
        tbl[17] = '{1'b1, 4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3, "clr_with_hs_3"};
        tbl[18] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, "after_clr_rr0"};

        @(posedge clk);
        #1;
        check_outs("in_reset", 1'b0, 4'b0000, 2'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        for (int v = 0; v < 19; v++) begin
            apply(tbl[v].clr, tbl[v].valid, tbl[v].ready,
                  tbl[v].ev, tbl[v].er, tbl[v].ei, tbl[v].nm);
        end

        // Stall on input 2 while input 0 rises.
        apply(1'b0, 4'b0100, 1'b0, 1'b1, 4'b0000, 2'd2, "stall2_c1");
`ifdef STREAM_RR_ARBITER_LOCK_EN
        apply(1'b0, 4'b0101, 1'b0, 1'b1, 4'b0000, 2'd2, "stall2_c2_locked");
        apply(1'b0, 4'b0101, 1'b0, 1'b1, 4'b0000, 2'd2, "stall2_c3_locked");
        apply(1'b0, 4'b0101, 1'b1, 1'b1, 4'b0100, 2'd2, "stall2_c4_hs");
        apply(1'b0, 4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, "after_lock_wrap0");
`else
        apply(1'b0, 4'b0101, 1'b0, 1'b1, 4'b0000, 2'd0, "stall2_c2_switch");
        apply(1'b0, 4'b0101, 1'b0, 1'b1, 4'b0000, 2'd0, "stall2_c3_switch");
        apply(1'b0, 4'b0101, 1'b1, 1'b1, 4'b0001, 2'd0, "stall2_c4_hs0");
        apply(1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, "after_switch_2");
`endif

        // Clear during a stall releases any lock and rewinds the pointer.
        apply(1'b0, 4'b1000, 1'b0, 1'b1, 4'b0000, 2'd3, "clr_stall3");
        apply(1'b1, 4'b1001, 1'b0, 1'b1, 4'b0000, 2'd3, "clr_pulse");
        apply(1'b0, 4'b1001, 1'b1, 1'b1, 4'b0001, 2'd0, "after_clr_grant0");

        // Asynchronous reset while stalled.
        apply(1'b0, 4'b0100, 1'b0, 1'b1, 4'b0000, 2'd2, "rst_stall2");
`ifdef STREAM_RR_ARBITER_LOCK_EN
        apply(1'b0, 4'b0110, 1'b0, 1'b1, 4'b0000, 2'd2, "rst_stall2_held");
`else
        apply(1'b0, 4'b0110, 1'b0, 1'b1, 4'b0000, 2'd1, "rst_stall_switch1");
`endif
        #1;
        rst_ni = 1'b0;
        #1;
        check_outs("async_rst_grant1", 1'b1, 4'b0000, 2'd1);
        bus.valid_i = 4'b0000;
        #1;
        check_outs("async_rst_idle", 1'b0, 4'b0000, 2'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        apply(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, "post_rst_0");
        apply(1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, "post_rst_1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule : tb_stream_rr_arbiter
`default_nettype wire
